// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: handshake bundle between the UART receive FIFO and its users.
//   master : producer/consumer side (drives wr_tick, wr_data, rd_en, err_clr)
//   slave  : FIFO side (drives rd_data, empty, full, count, overflow, underflow)
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_tick;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_tick, wr_data, rd_en, err_clr,
    input  rd_data, empty, full, count, overflow, underflow
  );

  modport slave (
    input  wr_tick, wr_data, rd_en, err_clr,
    output rd_data, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer behind the UART receiver.
// Ports:
//   clk       system clock, posedge
//   reset_in  synchronous active-low reset
//   bus       uart_rx_fifo_if.slave: wr_tick/wr_data write strobe and byte,
//             rd_en pop, err_clr sticky-flag clear; rd_data head byte,
//             empty/full/count occupancy, overflow/underflow sticky errors.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset_in,
  uart_rx_fifo_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  pop;
  logic                  wr_accept;

  always_comb begin
    pop         = bus.rd_en & ~empty_q;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    wr_accept   = bus.wr_tick & (~full_q | pop);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

    if (wr_accept && !pop)      count_d = count_q + CW'(1);
    else if (pop && !wr_accept) count_d = count_q - CW'(1);

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);

    // Clear first so a same-cycle error takes priority.
    if (bus.err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wr_tick && !wr_accept) overflow_d  = 1'b1;
    if (bus.rd_en && empty_q)      underflow_d = 1'b1;

    // Track the head while non-empty so the last value stays on rd_data once
    // the FIFO drains; it is reset to 0 so stale memory never shows.
    hold_d = empty_q ? hold_q : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      hold_q      <= hold_d;
    end
  end

  // Storage is not cleared by reset; empty gates it away from rd_data.
  always_ff @(posedge clk) begin
    if (reset_in && wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.rd_data   = empty_q ? hold_q : mem_q[rd_ptr_q];
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic reset_in;
  int   n_cmp = 0;
  int   n_err = 0;

  uart_rx_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         rs;
    bit         wt;
    logic [7:0] wd;
    bit         re;
    bit         ec;
    bit         e_empty;
    bit         e_full;
    int         e_count;
    bit         chk_d;
    logic [7:0] e_data;
    bit         e_ovf;
    bit         e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the edge.
  task automatic cyc(input bit rs, input bit wt, input logic [7:0] wd,
                     input bit re, input bit ec);
    reset_in    = ~rs;
    bus.wr_tick = wt;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.err_clr = ec;
    @(posedge clk);
    #1;
    reset_in    = 1'b1;
    bus.wr_tick = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  function automatic vec_t mk(string nm, bit rs, bit wt, logic [7:0] wd, bit re, bit ec,
                              bit e_empty, bit e_full, int e_count, bit chk_d,
                              logic [7:0] e_data, bit e_ovf, bit e_unf);
    vec_t v;
    v.name = nm; v.rs = rs; v.wt = wt; v.wd = wd; v.re = re; v.ec = ec;
    v.e_empty = e_empty; v.e_full = e_full; v.e_count = e_count;
    v.chk_d = chk_d; v.e_data = e_data; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, base + 8'(i), 0, 0);
      chk("fill_count", 32'(bus.count), 32'(i + 1));
    end
    chk("fill_full", 32'(bus.full), 32'd1);
  endtask

  initial begin
    reset_in    = 1'b1;
    bus.wr_tick = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;

    //                 name        rs wt wd     re ec  emp ful cnt chkd data  ovf unf
    vecs.push_back(mk("reset",     1, 0, 8'h00, 0, 0,  1,  0,  0,  1, 8'h00, 0, 0));
    vecs.push_back(mk("wr_a5",     0, 1, 8'hA5, 0, 0,  0,  0,  1,  1, 8'hA5, 0, 0));
    vecs.push_back(mk("pop_a5",    0, 0, 8'h00, 1, 0,  1,  0,  0,  1, 8'hA5, 0, 0));
    vecs.push_back(mk("idle",      0, 0, 8'h00, 0, 0,  1,  0,  0,  1, 8'hA5, 0, 0));
    vecs.push_back(mk("unf_rd",    0, 0, 8'h00, 1, 0,  1,  0,  0,  0, 8'h00, 0, 1));
    vecs.push_back(mk("wr_rd_emp", 0, 1, 8'h3C, 1, 0,  0,  0,  1,  1, 8'h3C, 0, 1));
    vecs.push_back(mk("clr_unf",   0, 0, 8'h00, 0, 1,  0,  0,  1,  1, 8'h3C, 0, 0));
    vecs.push_back(mk("pop_3c",    0, 0, 8'h00, 1, 0,  1,  0,  0,  1, 8'h3C, 0, 0));
    vecs.push_back(mk("clr_vs_rd", 0, 0, 8'h00, 1, 1,  1,  0,  0,  0, 8'h00, 0, 1));
    vecs.push_back(mk("clr_only",  0, 0, 8'h00, 0, 1,  1,  0,  0,  0, 8'h00, 0, 0));
    vecs.push_back(mk("burst_1",   0, 1, 8'h01, 0, 0,  0,  0,  1,  1, 8'h01, 0, 0));
    vecs.push_back(mk("burst_2",   0, 1, 8'h02, 0, 0,  0,  0,  2,  1, 8'h01, 0, 0));
    vecs.push_back(mk("burst_3",   0, 1, 8'h03, 0, 0,  0,  0,  3,  1, 8'h01, 0, 0));
    vecs.push_back(mk("burst_4",   0, 1, 8'h04, 0, 0,  0,  0,  4,  1, 8'h01, 0, 0));
    vecs.push_back(mk("burst_5",   0, 1, 8'h05, 1, 0,  0,  0,  4,  1, 8'h02, 0, 0));
    vecs.push_back(mk("mid_reset", 1, 1, 8'hEE, 0, 0,  1,  0,  0,  1, 8'h00, 0, 0));
    vecs.push_back(mk("wr_81",     0, 1, 8'h81, 0, 0,  0,  0,  1,  1, 8'h81, 0, 0));
    vecs.push_back(mk("wr_rd_one", 0, 1, 8'h82, 1, 0,  0,  0,  1,  1, 8'h82, 0, 0));
    vecs.push_back(mk("pop_82",    0, 0, 8'h00, 1, 0,  1,  0,  0,  1, 8'h82, 0, 0));

    foreach (vecs[k]) begin
      cyc(vecs[k].rs, vecs[k].wt, vecs[k].wd, vecs[k].re, vecs[k].ec);
      chk({vecs[k].name, "_empty"}, 32'(bus.empty), 32'(vecs[k].e_empty));
      chk({vecs[k].name, "_full"},  32'(bus.full),  32'(vecs[k].e_full));
      chk({vecs[k].name, "_count"}, 32'(bus.count), 32'(vecs[k].e_count));
      chk({vecs[k].name, "_ovf"},   32'(bus.overflow),  32'(vecs[k].e_ovf));
      chk({vecs[k].name, "_unf"},   32'(bus.underflow), 32'(vecs[k].e_unf));
      if (vecs[k].chk_d) chk({vecs[k].name, "_data"}, 32'(bus.rd_data), 32'(vecs[k].e_data));
    end

    // Fill 0x00..0x0F, drain in order, pointers wrap to 0.
    cyc(1, 0, 8'h00, 0, 0);
    fill16(8'h00);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(bus.rd_data), 32'(i));
      cyc(0, 0, 8'h00, 1, 0);
      chk("drain_count", 32'(bus.count), 32'(15 - i));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("wrap_wr_ptr", 32'(dut.wr_ptr_q), 32'd0);
    chk("wrap_rd_ptr", 32'(dut.rd_ptr_q), 32'd0);

    // Overflow while full, contents intact, clear vs new-error priority.
    cyc(1, 0, 8'h00, 0, 0);
    fill16(8'h00);
    cyc(0, 1, 8'h77, 0, 0);
    chk("ovf_set",   32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count),    32'd16);
    cyc(0, 1, 8'h78, 0, 1);
    chk("ovf_clr_vs_new", 32'(bus.overflow), 32'd1);
    cyc(0, 0, 8'h00, 0, 1);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_readback", 32'(bus.rd_data), 32'(i));
      cyc(0, 0, 8'h00, 1, 0);
    end
    chk("ovf_drained", 32'(bus.empty), 32'd1);

    // Full with simultaneous write and pop: count holds, 0x55 ends up last.
    fill16(8'h00);
    cyc(0, 1, 8'h55, 1, 0);
    chk("fullwr_count", 32'(bus.count),    32'd16);
    chk("fullwr_full",  32'(bus.full),     32'd1);
    chk("fullwr_ovf",   32'(bus.overflow), 32'd0);
    chk("fullwr_head",  32'(bus.rd_data),  32'h01);
    for (int i = 0; i < 16; i++) begin
      chk("fullwr_order", 32'(bus.rd_data), (i < 15) ? 32'(i + 1) : 32'h55);
      cyc(0, 0, 8'h00, 1, 0);
    end
    chk("fullwr_empty", 32'(bus.empty), 32'd1);
    chk("fullwr_unf",   32'(bus.underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
